// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the piso_serializer block.
// Optional feature macro: PISO_PARITY_EN (appends an even-parity bit to each word).
package piso_pkg;

  // Serializer control states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  // Default word width used when the top is instantiated without overrides.
  localparam int PISO_DEFAULT_WIDTH = 4;

`ifdef PISO_PARITY_EN
  // One extra serial bit carries the even parity of the captured word.
  localparam int PISO_PARITY_BITS = 1;
`else
  localparam int PISO_PARITY_BITS = 0;
`endif

  // Bit counter width; sized for WIDTH+1 so the parity slot fits.
  function automatic int piso_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Counter value of the final serial bit of a word.
  function automatic int piso_term_cnt(input int width);
    return width - 1 + PISO_PARITY_BITS;
  endfunction

  // Counter width and terminal count for the default word width.
  localparam int PISO_DEFAULT_CNT_W = $clog2(PISO_DEFAULT_WIDTH + 1);
  localparam int PISO_DEFAULT_TERM  = PISO_DEFAULT_WIDTH - 1 + PISO_PARITY_BITS;

endpackage

// File: rtl/piso_shreg.sv
// Loadable WIDTH-bit shift register with selectable shift direction.
// The serial output is the first-out flop bit; vacated positions take si.
module piso_shreg
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d,
  input  logic             si,
  output logic             so
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next register contents: parallel load wins over shifting.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (shift_en) begin
      if (LSB_FIRST) begin
        q_d = {si, q_q[WIDTH-1:1]};
      end else begin
        q_d = {q_q[WIDTH-2:0], si};
      end
    end else begin
      q_d = q_q;
    end
  end

  // Register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign so = LSB_FIRST ? q_q[0] : q_q[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: captures a word on load when ready,
// shifts it out one bit per clock with a valid strobe and a done pulse on
// the last bit. Optional feature macro: PISO_PARITY_EN (trailing even-parity bit).
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CNT_W = piso_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(piso_term_cnt(WIDTH));
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  piso_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             sout_valid_q, sout_valid_d;
  logic             done_q, done_d;
  logic             accept_s;
  logic             shift_en_s;
  logic             si_s;
  logic             so_s;

  // Next state, bit counter and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept_s   = 1'b0;
    shift_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          accept_s = 1'b1;
          cnt_d    = CNT_ZERO;
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        shift_en_s = 1'b1;
        if (cnt_q == TERM) begin
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = SHIFT;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = IDLE;
      end
    endcase
    ready_d      = (state_d == IDLE);
    sout_valid_d = (state_d == SHIFT);
    done_d       = (state_d == SHIFT) && (cnt_d == TERM);
  end

  // State, counter and handshake output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      ready_q      <= 1'b1;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
    end
  end

`ifdef PISO_PARITY_EN
  logic parity_q, parity_d;

  // Parity of the captured word; fed into the far end on the first shift
  // so it reaches the output right after the last data bit.
  always_comb begin
    parity_d = parity_q;
    if (accept_s) begin
      parity_d = ^d;
    end else begin
      parity_d = parity_q;
    end
    if ((state_q == SHIFT) && (cnt_q == CNT_ZERO)) begin
      si_s = parity_q;
    end else begin
      si_s = 1'b0;
    end
  end

  // Parity holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`else
  // Zeros fill the register so sout returns to 0 once the word has drained.
  assign si_s = 1'b0;
`endif

  piso_shreg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .shift_en (shift_en_s),
    .d        (d),
    .si       (si_s),
    .so       (so_s)
  );

  assign ready      = ready_q;
  assign sout       = so_s;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: one LSB-first and one MSB-first
// instance share stimulus and are compared against a queue-based model of
// the serial bit stream.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] d = '0;
  logic         ready_l, sout_l, valid_l, done_l;
  logic         ready_m, sout_m, valid_m, done_m;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Bits still to appear on sout, head = bit shown in the current cycle.
  bit q_l[$];
  bit q_m[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .load(load), .d(d),
    .ready(ready_l), .sout(sout_l), .sout_valid(valid_l), .done(done_l)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .load(load), .d(d),
    .ready(ready_m), .sout(sout_m), .sout_valid(valid_m), .done(done_m)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    bit busy;
    busy = (q_l.size() != 0);
    chk("lsb_ready", ready_l, !busy);
    chk("lsb_valid", valid_l, busy);
    chk("lsb_sout",  sout_l,  busy ? q_l[0] : 1'b0);
    chk("lsb_done",  done_l,  q_l.size() == 1);
    chk("msb_ready", ready_m, !busy);
    chk("msb_valid", valid_m, busy);
    chk("msb_sout",  sout_m,  busy ? q_m[0] : 1'b0);
    chk("msb_done",  done_m,  q_m.size() == 1);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check.
  task automatic step(input logic r, input logic l, input logic [W-1:0] dv);
    @(negedge clk);
    rst  = r;
    load = l;
    d    = dv;
    @(posedge clk);
    if (r) begin
      q_l.delete();
      q_m.delete();
    end else if (q_l.size() == 0) begin
      if (l) begin
        for (int i = 0; i < W; i++) begin
          q_l.push_back(dv[i]);
          q_m.push_back(dv[W-1-i]);
        end
        if (PAR != 0) begin
          q_l.push_back(^dv);
          q_m.push_back(^dv);
        end
      end
    end else begin
      void'(q_l.pop_front());
      void'(q_m.pop_front());
    end
    #1;
    cyc++;
    check_all();
  endtask

  initial begin
    // Reset held with load asserted: nothing may be captured.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'hF);

    // Single word 1011, then idle long enough to see ready return.
    step(1'b0, 1'b1, 4'b1011);
    for (int i = 0; i < W + PAR + 2; i++) step(1'b0, 1'b0, 4'h0);

    // load held high: 6 in flight, d switches to 9 mid-word.
    step(1'b0, 1'b1, 4'h6);
    step(1'b0, 1'b1, 4'h6);
    for (int i = 0; i < 2 * (W + PAR + 1); i++) step(1'b0, 1'b1, 4'h9);
    for (int i = 0; i < W + PAR + 2; i++) step(1'b0, 1'b0, 4'h0);

    // Reset in the second shift cycle of word A.
    step(1'b0, 1'b1, 4'hA);
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < W + 2; i++) step(1'b0, 1'b0, 4'h0);

    // Word 0111 (parity bit 1 when the parity slot is built in).
    step(1'b0, 1'b1, 4'b0111);
    for (int i = 0; i < W + PAR + 2; i++) step(1'b0, 1'b0, 4'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
           $urandom_range(0, 1) != 0,
           W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
